// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the iterative core.
// The S-box is a plain 256-entry table, and GF(2^8) doubling is xtime.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    if (b[7]) return {b[6:0], 1'b0} ^ 8'h1b;
    else      return {b[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Out-of-range indices only occur while the schedule output is unused.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i < 4'd10) return RCON[i];
    else           return 8'h00;
  endfunction

  function automatic int nr_for_keybits(input int kb);
    if (kb == 256) return 14;
    else           return 10;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// last is high) and AddRoundKey. Byte (row r, col c) lives at state_t[3-c][3-r].
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_state
);

  state_t in_s, sb_s, sr_s, mc_s;

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign in_s = state;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb_s[3-c][3-r] = sbox(in_s[3-c][3-r]);
      assign sr_s[3-c][3-r] = sb_s[3-((c+r)%4)][3-r];
    end
    assign mc_s[3-c] = mix_col(sr_s[3-c]);
  end

  assign next_state = last ? (sr_s ^ rk) : (mc_s ^ rk);

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per clock, on-the-fly key
// schedule in a sliding window. Define AES_ZEROIZE_EN to wipe state/key on done.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        plaintext,
  output logic [127:0]        cyphertext,
  output logic                busy,
  output logic                done
);

  localparam int         NR       = nr_for_keybits(KEY_BITS);
  localparam logic [3:0] RND_LAST = 4'(NR - 1);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_keybits
    $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
  end

  fsm_t                st_r, st_nxt_s;
  logic                accept_s, round_s, final_s;
  logic [3:0]          rnd_r;
  logic [127:0]        state_r, rk_s, rnd_out_s;
  logic [KEY_BITS-1:0] key_win_r, key_next_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) st_r <= ST_IDLE;
    else          st_r <= st_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    st_nxt_s = st_r;
    case (st_r)
      ST_IDLE: begin
        if (load) st_nxt_s = ST_ROUND;
        else      st_nxt_s = ST_IDLE;
      end
      ST_ROUND: begin
        if (rnd_r == RND_LAST) st_nxt_s = ST_FINAL;
        else                   st_nxt_s = ST_ROUND;
      end
      ST_FINAL: st_nxt_s = ST_IDLE;
      default:  st_nxt_s = ST_IDLE;
    endcase
  end

  // FSM decoded controls for the datapath
  always_comb begin
    accept_s = 1'b0;
    round_s  = 1'b0;
    final_s  = 1'b0;
    case (st_r)
      ST_IDLE:  accept_s = load;
      ST_ROUND: round_s  = 1'b1;
      ST_FINAL: final_s  = 1'b1;
      default:  accept_s = 1'b0;
    endcase
  end

  if (KEY_BITS == 128) begin : g_ks128
    logic [31:0] t_s, n0_s, n1_s, n2_s, n3_s;
    // Window holds rk(rnd-1); the freshly expanded four words are rk(rnd)
    always_comb begin
      t_s  = sub_word(rot_word(key_win_r[31:0])) ^ {rcon_at(rnd_r - 4'd1), 24'h000000};
      n0_s = key_win_r[127:96] ^ t_s;
      n1_s = key_win_r[95:64]  ^ n0_s;
      n2_s = key_win_r[63:32]  ^ n1_s;
      n3_s = key_win_r[31:0]   ^ n2_s;
      rk_s       = {n0_s, n1_s, n2_s, n3_s};
      key_next_s = {n0_s, n1_s, n2_s, n3_s};
    end
  end else begin : g_ks256
    logic [31:0] t_s, n0_s, n1_s, n2_s, n3_s;
    // Window holds w[4(rnd-1) .. 4(rnd-1)+7]; its lower half is rk(rnd)
    always_comb begin
      if (rnd_r[0]) begin
        t_s = sub_word(rot_word(key_win_r[31:0])) ^ {rcon_at({1'b0, rnd_r[3:1]}), 24'h000000};
      end else begin
        t_s = sub_word(key_win_r[31:0]);
      end
      n0_s = key_win_r[255:224] ^ t_s;
      n1_s = key_win_r[223:192] ^ n0_s;
      n2_s = key_win_r[191:160] ^ n1_s;
      n3_s = key_win_r[159:128] ^ n2_s;
      rk_s       = key_win_r[127:0];
      key_next_s = {key_win_r[127:0], n0_s, n1_s, n2_s, n3_s};
    end
  end

  aes_round_comb u_round (
    .state      (state_r),
    .rk         (rk_s),
    .last       (final_s),
    .next_state (rnd_out_s)
  );

  // Datapath and handshake registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= '0;
      key_win_r  <= '0;
      rnd_r      <= 4'd0;
      cyphertext <= 128'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (accept_s) begin
      state_r    <= plaintext ^ key[KEY_BITS-1 -: 128];
      key_win_r  <= key;
      rnd_r      <= 4'd1;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (round_s) begin
      state_r    <= rnd_out_s;
      key_win_r  <= key_next_s;
      rnd_r      <= rnd_r + 4'd1;
    end else if (final_s) begin
      cyphertext <= rnd_out_s;
      busy       <= 1'b0;
      done       <= 1'b1;
`ifdef AES_ZEROIZE_EN
      state_r    <= '0;
      key_win_r  <= '0;
`else
      state_r    <= state_r;
      key_win_r  <= key_win_r;
`endif
    end
  end

endmodule
